// File: rtl/bram_com_ctrl_if.sv
// rtl/bram_com_ctrl_if.sv - EPP host port and BRAM port signal bundle
interface bram_com_ctrl_if #(
  parameter int ADDR_W = 12
);
  // EPP host side
  logic              stb_data;
  logic              ctrl_wr;
  logic [7:0]        epp_in;
  logic [7:0]        epp_out;
  logic [7:0]        epp_addr_in;
  // BRAM side
  logic [ADDR_W-1:0] bram_addr;
  logic [7:0]        bram_in;
  logic [7:0]        bram_out;
  logic              we_bram;
  logic              clk_bram;

  // Environment view: drives the host pins and returns BRAM read data
  modport master (
    output stb_data, ctrl_wr, epp_in, epp_addr_in, bram_in,
    input  epp_out, bram_addr, bram_out, we_bram, clk_bram
  );

  // Controller view
  modport slave (
    input  stb_data, ctrl_wr, epp_in, epp_addr_in, bram_in,
    output epp_out, bram_addr, bram_out, we_bram, clk_bram
  );
endinterface

// File: rtl/bram_com_ctrl.sv
// rtl/bram_com_ctrl.sv - EPP host port to 8-bit single-port BRAM bridge with auto-increment
module bram_com_ctrl #(
  parameter int         ADDR_W   = 12,
  parameter logic [7:0] REG_DATA = 8'h00,
  parameter logic [7:0] REG_AHI  = 8'h40,
  parameter logic [7:0] REG_ALO  = 8'h80
) (
  input logic            clk,
  input logic            rst,
  bram_com_ctrl_if.slave bus
);

  // DISARMED: no genuine high strobe seen since reset; strobe edges are ignored.
  // IDLE:     waiting for the strobe to fall.
  // ACTIVE:   strobe is low, the selected register is held until it rises.
  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_IDLE     = 2'd1,
    ST_ACTIVE   = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic              s1;
  logic              s2;
  logic              s3;
  logic              v1;
  logic              v2;
  logic              fall;
  logic              rise;
  logic              do_fall;
  logic              do_rise;
  logic [7:0]        held_addr;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wdata_q;
  logic              we_q;
  logic [7:0]        ahi_rd;
  logic [7:0]        rd_mux;

  // Strobe synchronizer and history flop. v1/v2 mark when s2 carries a real
  // sample of the pin instead of its reset value, so a strobe held low
  // across reset release cannot arm the controller.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      s1 <= bus.stb_data;
      s2 <= s1;
      s3 <= s2;
      v1 <= 1'b1;
      v2 <= v1;
    end
  end

  assign fall = s3 & ~s2;
  assign rise = ~s3 & s2;

  // Strobe-tracking state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_DISARMED;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and edge qualification: edges only act when armed and in order
  always_comb begin
    state_nxt = state;
    do_fall   = 1'b0;
    do_rise   = 1'b0;
    case (state)
      ST_DISARMED: begin
        if (v2 && s2) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (fall) begin
          do_fall   = 1'b1;
          state_nxt = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (rise) begin
          do_rise   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_DISARMED;
      end
    endcase
  end

  // Register file update: address/data writes on fall, auto-increment on rise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q    <= '0;
      wdata_q   <= 8'h00;
      we_q      <= 1'b0;
      held_addr <= 8'h00;
    end else begin
      we_q <= 1'b0;
      if (do_fall) begin
        held_addr <= bus.epp_addr_in;
        if (!bus.ctrl_wr) begin
          case (bus.epp_addr_in)
            REG_AHI: addr_q[ADDR_W-1:8] <= bus.epp_in[ADDR_W-9:0];
            REG_ALO: addr_q[7:0]        <= bus.epp_in;
            REG_DATA: begin
              wdata_q <= bus.epp_in;
              we_q    <= 1'b1;
            end
            default: ;
          endcase
        end
      end
      // The strobe lasts >= 3 clocks, so this never overlaps the write pulse
      if (do_rise && (held_addr == REG_DATA)) begin
        addr_q <= addr_q + ADDR_W'(1);
      end
    end
  end

  // Zero-extended high address part for host reads
  always_comb begin
    ahi_rd               = 8'h00;
    ahi_rd[ADDR_W-9:0]   = addr_q[ADDR_W-1:8];
  end

  // Host read mux follows the live register select
  always_comb begin
    rd_mux = 8'h00;
    case (bus.epp_addr_in)
      REG_DATA: rd_mux = bus.bram_in;
      REG_AHI:  rd_mux = ahi_rd;
      REG_ALO:  rd_mux = addr_q[7:0];
      default:  rd_mux = 8'h00;
    endcase
  end

  // BRAM samples on the falling edge of clk, mid-way through the register hold
  assign bus.clk_bram  = ~clk;
  assign bus.bram_addr = addr_q;
  assign bus.bram_out  = wdata_q;
  assign bus.we_bram   = we_q;
  assign bus.epp_out   = rd_mux;

endmodule

// File: tb/tb_bram_com_ctrl.sv
// tb/tb_bram_com_ctrl.sv - randomized self-checking bench for bram_com_ctrl
module tb_bram_com_ctrl;
  localparam int ADDR_W = 12;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  bram_com_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  bram_com_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Single-port BRAM stand-in, read-first, clocked by clk_bram
  logic [7:0] bram_mem [0:DEPTH-1];
  always @(posedge bus.clk_bram) begin
    if (bus.we_bram) bram_mem[bus.bram_addr] <= bus.bram_out;
    bus.bram_in <= bram_mem[bus.bram_addr];
  end

  // Log of every clock cycle the write enable is seen high
  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [7:0]        d;
  } we_ev_t;
  we_ev_t we_log [$];
  always @(negedge clk) begin
    if (bus.we_bram === 1'b1) we_log.push_back('{bus.bram_addr, bus.bram_out});
  end

  // Reference model: expected memory contents and address pointer
  logic [7:0] ref_mem [0:DEPTH-1];
  int         ref_addr;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One complete host strobe; model is updated from the register rules
  task automatic host_op(input bit rd, input logic [7:0] a, input logic [7:0] d);
    logic [7:0] exp_rd;
    int         exp_we;
    int         exp_a;
    int         lo;
    int         hi;
    exp_rd = 8'h00;
    exp_we = 0;
    exp_a  = 0;
    if (rd) begin
      case (a)
        8'h00:   exp_rd = ref_mem[ref_addr];
        8'h40:   exp_rd = 8'(ref_addr / 256);
        8'h80:   exp_rd = 8'(ref_addr % 256);
        default: exp_rd = 8'h00;
      endcase
    end else begin
      case (a)
        8'h40: ref_addr = (ref_addr % 256) + 256 * int'(d % 16);
        8'h80: ref_addr = (ref_addr / 256) * 256 + int'(d);
        8'h00: begin
          exp_we            = 1;
          exp_a             = ref_addr;
          ref_mem[ref_addr] = d;
        end
        default: ;
      endcase
    end
    if (a == 8'h00) ref_addr = (ref_addr + 1) % DEPTH;

    @(negedge clk);
    we_log.delete();
    bus.ctrl_wr     = rd;
    bus.epp_addr_in = a;
    bus.epp_in      = d;
    @(negedge clk);
    bus.stb_data = 1'b0;
    lo = $urandom_range(3, 6);
    repeat (lo) @(negedge clk);
    if (rd) chk($sformatf("rd[%0h]", a), 32'(bus.epp_out), 32'(exp_rd));
    bus.stb_data = 1'b1;
    hi = $urandom_range(5, 8);
    repeat (hi) @(negedge clk);
    chk("we_cnt", we_log.size(), exp_we);
    if (exp_we != 0 && we_log.size() > 0) begin
      chk("we_addr", 32'(we_log[0].a), exp_a);
      chk("we_data", 32'(we_log[0].d), 32'(d));
    end
    chk($sformatf("addr_after[%0h]", a), 32'(bus.bram_addr), ref_addr);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int r;
    logic [7:0] a;
    for (int i = 0; i < DEPTH; i++) begin
      bram_mem[i] = 8'($urandom);
      ref_mem[i]  = bram_mem[i];
    end
    ref_addr        = 0;
    rst             = 1'b1;
    bus.stb_data    = 1'b1;
    bus.ctrl_wr     = 1'b1;
    bus.epp_in      = 8'h00;
    bus.epp_addr_in = 8'h40;
    repeat (3) @(negedge clk);
    chk("rst_addr", 32'(bus.bram_addr), 0);
    chk("rst_out", 32'(bus.bram_out), 0);
    chk("rst_we", 32'(bus.we_bram), 0);
    chk("rst_ahi_rd", 32'(bus.epp_out), 0);
    chk("clk_bram", 32'(bus.clk_bram), 1);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Address setup then single write
    host_op(0, 8'h40, 8'h03);
    host_op(0, 8'h80, 8'h00);
    host_op(0, 8'h00, 8'hFF);

    // Burst of writes from address 0
    host_op(0, 8'h40, 8'h00);
    host_op(0, 8'h80, 8'h00);
    for (int i = 0; i < 7; i++) host_op(0, 8'h00, 8'(i));

    // Read back with carry into the high part
    host_op(0, 8'h40, 8'h0A);
    host_op(0, 8'h80, 8'hFF);
    host_op(1, 8'h00, 8'h00);
    host_op(1, 8'h40, 8'h00);
    host_op(1, 8'h80, 8'h00);

    // Wrap at the top of memory (upper nibble of epp_in ignored)
    host_op(0, 8'hF0 | 8'h40 ^ 8'hF0, 8'hFF);
    host_op(0, 8'h40, 8'hEF);
    host_op(0, 8'h80, 8'hFF);
    host_op(0, 8'h00, 8'h5A);

    // Unmapped register
    host_op(0, 8'h20, 8'h77);
    host_op(1, 8'h20, 8'h00);

    // Readback of earlier writes
    host_op(0, 8'h40, 8'h00);
    host_op(0, 8'h80, 8'h02);
    host_op(1, 8'h00, 8'h00);

    // Reset while a data-write strobe is low, released with strobe still low
    host_op(0, 8'h40, 8'h05);
    @(negedge clk);
    bus.ctrl_wr     = 1'b0;
    bus.epp_addr_in = 8'h00;
    bus.epp_in      = 8'h99;
    @(negedge clk);
    we_log.delete();
    bus.stb_data = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_out", 32'(bus.bram_out), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    bus.stb_data = 1'b1;
    repeat (7) @(negedge clk);
    chk("midrst_we_cnt", we_log.size(), 0);
    chk("midrst_addr", 32'(bus.bram_addr), 0);
    ref_addr = 0;

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 9);
      if (r < 5)      a = 8'h00;
      else if (r < 7) a = 8'h40;
      else if (r < 9) a = 8'h80;
      else            a = 8'($urandom);
      host_op(bit'($urandom_range(0, 1)), a, 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
